// File: rtl/simt_mask_stack.sv
// Per-warp SIMT divergence stack holding lane masks, else-masks and reconvergence PCs.
// One op per cycle, visible on the combinational read port next cycle; no backpressure.
module simt_mask_stack #(
    parameter  int LANES = 8,
    parameter  int DEPTH = 8,
    parameter  int WARPS = 4,
    parameter  int PC_W  = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int WID_W = (WARPS > 1) ? $clog2(WARPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WID_W-1:0] op_warp,
    input  logic [LANES-1:0] op_cond,
    input  logic [PC_W-1:0]  op_rpc,
    input  logic [WID_W-1:0] rd_warp,
    output logic [LANES-1:0] rd_mask,
    output logic [LANES-1:0] rd_else,
    output logic [PC_W-1:0]  rd_rpc,
    output logic [PTR_W-1:0] rd_depth,
    output logic             all_active,
    output logic             none_active,
    output logic             err_overflow,
    output logic             err_underflow
);
    localparam logic [1:0]       OP_PUSH = 2'b01;
    localparam logic [1:0]       OP_ELSE = 2'b10;
    localparam logic [1:0]       OP_POP  = 2'b11;
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [LANES-1:0] r_mask [WARPS][DEPTH];
    logic [LANES-1:0] r_else [WARPS][DEPTH];
    logic [PC_W-1:0]  r_rpc  [WARPS][DEPTH];
    logic [PTR_W-1:0] r_ptr  [WARPS];
    logic             r_err_ovf;
    logic             r_err_unf;

    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic [LANES-1:0] w_cur_mask;
    logic [LANES-1:0] w_cur_else;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_else;
    logic             w_pop;

    assign w_ptr      = r_ptr[op_warp];
    assign w_ptr_inc  = w_ptr + PTR_ONE;
    assign w_ptr_dec  = w_ptr - PTR_ONE;
    assign w_cur_mask = r_mask[op_warp][w_ptr];
    assign w_cur_else = r_else[op_warp][w_ptr];
    assign w_full     = (w_ptr == PTR_MAX);
    assign w_empty    = (w_ptr == '0);
    assign w_push     = op_valid && (op == OP_PUSH);
    assign w_else     = op_valid && (op == OP_ELSE);
    assign w_pop      = op_valid && (op == OP_POP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < WARPS; w++) begin
                r_ptr[w] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_mask[w][d] <= (d == 0) ? '1 : '0;
                    r_else[w][d] <= '0;
                    r_rpc[w][d]  <= '0;
                end
            end
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= w_push && w_full;
            r_err_unf <= (w_pop || w_else) && w_empty;
            if (w_push && !w_full) begin
                // New top splits the current mask into taken lanes and deferred else lanes.
                r_ptr[op_warp]             <= w_ptr_inc;
                r_mask[op_warp][w_ptr_inc] <= w_cur_mask & op_cond;
                r_else[op_warp][w_ptr_inc] <= w_cur_mask & ~op_cond;
                r_rpc[op_warp][w_ptr_inc]  <= op_rpc;
            end
            if (w_else && !w_empty) begin
                r_mask[op_warp][w_ptr] <= w_cur_else;
                r_else[op_warp][w_ptr] <= '0;
            end
            if (w_pop && !w_empty) begin
                r_ptr[op_warp] <= w_ptr_dec;
            end
        end
    end

    assign rd_depth      = r_ptr[rd_warp];
    assign rd_mask       = r_mask[rd_warp][rd_depth];
    assign rd_else       = r_else[rd_warp][rd_depth];
    assign rd_rpc        = r_rpc[rd_warp][rd_depth];
    assign all_active    = &rd_mask;
    assign none_active   = ~|rd_mask;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_unf;
endmodule
